// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS (FPD-Link) transmit framer:
// lane-word geometry, clock-lane pattern, mapping modes and the pixel-to-lane mapper.
package lvds_tx_pkg;

    localparam int WORD_W    = 7;
    localparam int MAX_LANES = 4;

    localparam logic [WORD_W-1:0] CLK_PATTERN = 7'b1100011;

    typedef enum logic {
        MAP_JEIDA = 1'b0,
        MAP_VESA  = 1'b1
    } map_mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ctrl;
    } pixel_t;

    typedef logic [MAX_LANES-1:0][WORD_W-1:0] lane_words_t;

    // Word bit 6 is serialised first. The 3-lane (18-bit) layout, VESA order on
    // colour[7:2], is bit-identical to JEIDA lanes 0..2, so 3-lane callers pass MAP_JEIDA.
    function automatic lane_words_t map_pixel(input pixel_t p, input map_mode_t mode);
        lane_words_t w;
        if (mode == MAP_VESA) begin
            w[0] = {p.g[0], p.r[5:0]};
            w[1] = {p.b[1:0], p.g[5:1]};
            w[2] = {p.de, p.vs, p.hs, p.b[5:2]};
            w[3] = {p.ctrl, p.b[7:6], p.g[7:6], p.r[7:6]};
        end else begin
            w[0] = {p.g[2], p.r[7:2]};
            w[1] = {p.b[3:2], p.g[7:3]};
            w[2] = {p.de, p.vs, p.hs, p.b[7:4]};
            w[3] = {p.ctrl, p.b[1:0], p.g[1:0], p.r[1:0]};
        end
        return w;
    endfunction

endpackage

// File: rtl/lvds_tx_fifo.sv
// Synchronous pixel FIFO for the LVDS framer; ready is registered and already
// reflects this cycle's push/pop so it never overstates free space.
module lvds_tx_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
    logic             full, full_next, do_push, do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign wr_next   = wr_ptr + PW'(do_push);
    assign rd_next   = rd_ptr + PW'(do_pop);
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign full_next = (wr_next == {~rd_next[AW], rd_next[AW-1:0]});
    assign rdata     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            ready  <= !full_next;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/lvds_tx_framer.sv
// LVDS (FPD-Link) transmit framer in the 7x bit-clock domain, 3 or 4 data lanes.
// Optional colour-bar generator behind macro LVDS_TX_TEST_PATTERN_EN (adds test_en).
module lvds_tx_framer
    import lvds_tx_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int UFLOW_W    = 16
`ifdef LVDS_TX_TEST_PATTERN_EN
    ,
    parameter int H_ACTIVE   = 1024,
    parameter int BAR_W      = 128
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 map_vesa,
`ifdef LVDS_TX_TEST_PATTERN_EN
    input  logic                 test_en,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           r,
    input  logic [7:0]           g,
    input  logic [7:0]           b,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 de,
    input  logic                 ctrl,
    output logic [NUM_LANES-1:0] tx_data,
    output logic                 tx_clk,
    output logic [UFLOW_W-1:0]   underflow_cnt
);
    if (NUM_LANES != 3 && NUM_LANES != 4) begin : g_bad_lanes
        $error("lvds_tx_framer: NUM_LANES must be 3 or 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lvds_tx_framer: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    localparam logic [2:0] LAST_PHASE = 3'd6;

    logic [2:0]                       phase;
    logic                             load, pop, count_uflow, fifo_empty, held_hs, held_vs;
    pixel_t                           in_pix, head, frame_pix;
    map_mode_t                        active_mode, frame_mode;
    lane_words_t                      words, load_words;
    logic [WORD_W-1:0]                load_clk, clk_sh;
    logic [NUM_LANES-1:0][WORD_W-1:0] sh;

    assign load   = (phase == LAST_PHASE);
    assign in_pix = '{r: r, g: g, b: b, hs: hsync, vs: vsync, de: de, ctrl: ctrl};

    lvds_tx_fifo #(.WIDTH($bits(pixel_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid && in_ready),
        .wdata (in_pix),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .ready (in_ready)
    );

`ifdef LVDS_TX_TEST_PATTERN_EN
    localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    logic [X_W-1:0] bar_x;
    logic [2:0]     bar;
    pixel_t         pattern_pix;

    assign bar = 3'((int'(bar_x) / BAR_W) % 8);

    // Bars white..black: each component is on exactly when its bar-index bit is clear.
    always_comb begin
        pattern_pix    = '0;
        pattern_pix.r  = {8{~bar[1]}};
        pattern_pix.g  = {8{~bar[2]}};
        pattern_pix.b  = {8{~bar[0]}};
        pattern_pix.hs = held_hs;
        pattern_pix.vs = held_vs;
        pattern_pix.de = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bar_x <= '0;
        end else if (load && en && test_en) begin
            bar_x <= (bar_x == X_W'(H_ACTIVE - 1)) ? '0 : bar_x + X_W'(1);
        end
    end
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pop          = 1'b0;
        count_uflow  = 1'b0;
        frame_pix    = '0;
        frame_pix.hs = held_hs;
        frame_pix.vs = held_vs;
        frame_mode   = active_mode;
        if (load && en) begin
`ifdef LVDS_TX_TEST_PATTERN_EN
            if (test_en) begin
                frame_pix = pattern_pix;
            end else
`endif
            if (!fifo_empty) begin
                pop        = 1'b1;
                frame_pix  = head;
                frame_mode = (NUM_LANES == 4 && map_vesa) ? MAP_VESA : MAP_JEIDA;
            end else begin
                count_uflow = 1'b1;
            end
        end
        words      = map_pixel(frame_pix, frame_mode);
        load_words = en ? words : '0;
        load_clk   = en ? CLK_PATTERN : '0;
    end

    // The load cycle drives b6 directly so a word loaded at cycle t shows in t+1..t+7.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase         <= LAST_PHASE;
            tx_data       <= '0;
            tx_clk        <= 1'b0;
            sh            <= '0;
            clk_sh        <= '0;
            held_hs       <= 1'b0;
            held_vs       <= 1'b0;
            active_mode   <= MAP_JEIDA;
            underflow_cnt <= '0;
        end else begin
            phase <= load ? 3'd0 : phase + 3'd1;
            if (load) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    tx_data[l] <= load_words[l][WORD_W-1];
                    sh[l]      <= {load_words[l][WORD_W-2:0], 1'b0};
                end
                tx_clk <= load_clk[WORD_W-1];
                clk_sh <= {load_clk[WORD_W-2:0], 1'b0};
            end else begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    tx_data[l] <= sh[l][WORD_W-1];
                    sh[l]      <= {sh[l][WORD_W-2:0], 1'b0};
                end
                tx_clk <= clk_sh[WORD_W-1];
                clk_sh <= {clk_sh[WORD_W-2:0], 1'b0};
            end
            if (pop) begin
                held_hs     <= head.hs;
                held_vs     <= head.vs;
                active_mode <= frame_mode;
            end
            if (count_uflow && underflow_cnt != '1) begin
                underflow_cnt <= underflow_cnt + UFLOW_W'(1);
            end
        end
    end

endmodule
